// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared opcodes, FSM states and width default for seq_alu
// The DIV state only exists when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_REM = 3'b011,
        OP_DIV = 3'b100
    } op_t;

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;
`endif

    function automatic logic isDivOp(input logic [2:0] s);
        return (s == OP_REM) || (s == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// rtl/seq_alu_divider.sv - iterative restoring divider, one quotient bit per clock
// Used by seq_alu only when SEQ_ALU_DIV_EN is defined.
module seq_alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             lastIter,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // The dividend is shifted out of the quotient register MSB-first as quotient bits enter.
    assign trial    = {remainder, quotient[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs};
    assign lastIter = active && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvs       <= '0;
            cnt       <= '0;
            active    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            dvs       <= divisor;
            cnt       <= '0;
            active    <= 1'b1;
            quotient  <= dividend;
            remainder <= '0;
        end else if (active) begin
            if (trial >= {1'b0, dvs}) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (lastIter)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: add/sub in one step, shift-add mul, optional restoring div
// rem/div are built only with SEQ_ALU_DIV_EN; otherwise they report as reserved opcodes.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic [2:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               zeroFlag,
    output logic               divByZeroFlag,
    output logic               errFlag
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [2:0]         opSel;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic [2*WIDTH-1:0] finResult;
    logic               finDbz;
    logic               finErr;

    assign accept = start && !busy;

`ifdef SEQ_ALU_DIV_EN
    logic             divStart;
    logic             divLast;
    logic [WIDTH-1:0] divQuo;
    logic [WIDTH-1:0] divRem;

    assign divStart = accept && isDivOp(sel) && (num2 != '0);

    seq_alu_divider #(.WIDTH(WIDTH)) uDivider (
        .clk       (clk),
        .rst       (rst),
        .start     (divStart),
        .dividend  (num1),
        .divisor   (num2),
        .lastIter  (divLast),
        .quotient  (divQuo),
        .remainder (divRem)
    );
`endif

    // Values committed to the outputs when leaving S_DONE.
    always_comb begin
        finResult = '0;
        finDbz    = 1'b0;
        finErr    = 1'b0;
        case (opSel)
            OP_ADD: finResult = {{WIDTH{1'b0}}, opA} + {{WIDTH{1'b0}}, opB};
            OP_SUB: finResult = {{WIDTH{1'b0}}, opA} - {{WIDTH{1'b0}}, opB};
            OP_MUL: finResult = acc;
`ifdef SEQ_ALU_DIV_EN
            OP_REM: begin
                if (opB == '0) finDbz = 1'b1;
                else           finResult = {{WIDTH{1'b0}}, divRem};
            end
            OP_DIV: begin
                if (opB == '0) finDbz = 1'b1;
                else           finResult = {{WIDTH{1'b0}}, divQuo};
            end
`endif
            default: finErr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            zeroFlag      <= 1'b0;
            divByZeroFlag <= 1'b0;
            errFlag       <= 1'b0;
            opA           <= '0;
            opB           <= '0;
            opSel         <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opA    <= num1;
                        opB    <= num2;
                        opSel  <= sel;
                        busy   <= 1'b1;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, num1};
                        mplier <= num2;
                        cnt    <= '0;
                        if (sel == OP_MUL)
                            state <= S_MUL;
`ifdef SEQ_ALU_DIV_EN
                        else if (isDivOp(sel) && (num2 != '0))
                            state <= S_DIV;
`endif
                        else
                            state <= S_DONE;
                    end
                end
                S_MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= S_DONE;
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    if (divLast)
                        state <= S_DONE;
                end
`endif
                S_DONE: begin
                    result        <= finResult;
                    zeroFlag      <= (finResult == '0);
                    divByZeroFlag <= finDbz;
                    errFlag       <= finErr;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at WIDTH=8
// Expectations follow SEQ_ALU_DIV_EN when it is defined for the build.
module tb_seq_alu;

`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] res;
        logic        zf;
        logic        dbz;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic [2:0]  sel;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zeroFlag;
    logic        divByZeroFlag;
    logic        errFlag;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last;

    seq_alu #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num1          (num1),
        .num2          (num2),
        .sel           (sel),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .zeroFlag      (zeroFlag),
        .divByZeroFlag (divByZeroFlag),
        .errFlag       (errFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic divOp;
        divOp = DIV_EN && (s == 3'd3 || s == 3'd4);
        e.res = 16'h0;
        case (s)
            3'd0: e.res = 16'(a) + 16'(b);
            3'd1: e.res = 16'(a) - 16'(b);
            3'd2: e.res = 16'(a) * 16'(b);
            3'd3: if (divOp && b != 8'd0) e.res = 16'(a % b);
            3'd4: if (divOp && b != 8'd0) e.res = 16'(a / b);
            default: e.res = 16'h0;
        endcase
        e.err = (s > 3'd4) || (!DIV_EN && (s == 3'd3 || s == 3'd4));
        e.dbz = divOp && (b == 8'd0);
        e.zf  = (e.res == 16'h0);
        e.lat = (s == 3'd2 || (divOp && b != 8'd0)) ? 9 : 1;
        return e;
    endfunction

    // Drives a request in the current cycle and waits for its done pulse.
    task automatic runOp(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b, input bit midPulse);
        exp_t e;
        int   n;
        bit   seen;
        sb.push_back(model(s, a, b));
        start = 1'b1; sel = s; num1 = a; num2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
            end else if (midPulse) begin
                start = (n == 3);
                sel = 3'd0; num1 = 8'd1; num2 = 8'd1;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency",   32'(n),             32'(e.lat));
            chk("result",    32'(result),        32'(e.res));
            chk("zeroFlag",  32'(zeroFlag),      32'(e.zf));
            chk("dbzFlag",   32'(divByZeroFlag), 32'(e.dbz));
            chk("errFlag",   32'(errFlag),       32'(e.err));
            chk("busy_done", 32'(busy),          32'd0);
        end
        last = e;
    endtask

    initial begin
        int noDone;
        rst = 1'b1; start = 1'b0; num1 = '0; num2 = '0; sel = '0;
        #2;
        chk("reset_outputs", 32'({busy, done, zeroFlag, divByZeroFlag, errFlag, result}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        runOp(3'd0, 8'd200, 8'd100, 1'b0);
        runOp(3'd1, 8'd3,   8'd5,   1'b0);
        runOp(3'd1, 8'd7,   8'd7,   1'b0);
        runOp(3'd2, 8'd255, 8'd255, 1'b1);
        runOp(3'd3, 8'd100, 8'd7,   1'b0);
        runOp(3'd4, 8'd100, 8'd7,   1'b0);
        runOp(3'd3, 8'd5,   8'd0,   1'b0);
        runOp(3'd4, 8'd9,   8'd0,   1'b0);
        runOp(3'd5, 8'd12,  8'd3,   1'b0);
        runOp(3'd7, 8'd1,   8'd1,   1'b0);
        runOp(3'd3, 8'd9,   8'd4,   1'b0);
        runOp(3'd2, 8'd0,   8'd13,  1'b0);
        runOp(3'd4, 8'd255, 8'd1,   1'b0);
        for (int i = 0; i < 10; i++)
            runOp(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
        runOp(3'd2, 8'd13, 8'd11, 1'b0);

        // Result and flags must hold once done has dropped.
        @(posedge clk); #1;
        chk("done_pulse_width", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("result_hold", 32'(result), 32'(last.res));

        // Reset during a multiply aborts it.
        start = 1'b1; sel = 3'd2; num1 = 8'd255; num2 = 8'd255;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midop_reset_outputs", 32'({busy, done, zeroFlag, divByZeroFlag, errFlag, result}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        noDone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) noDone++;
        end
        chk("no_done_after_abort", 32'(noDone), 32'd0);
        runOp(3'd0, 8'd1, 8'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
